// File: rtl/line_clear_ctrl_pkg.sv
// Shared types and sizing for the line-clear sequencer.
package line_clear_ctrl_pkg;

  localparam int ROW_CNT          = 20;
  localparam int COL_CNT          = 10;
  localparam int COLOR_W          = 3;
  localparam int BLINK_FRAMES_DEF = 8;
  localparam int BLINK_CNT_DEF    = 3;

  // Row index, signed pointer (one bit wider so stepping below row 0 is visible),
  // and a line counter able to hold ROW_CNT.
  localparam int ROW_W   = $clog2(ROW_CNT);
  localparam int PTR_W   = ROW_W + 1;
  localparam int LINES_W = $clog2(ROW_CNT + 1);

  typedef logic [COLOR_W-1:0]               color_t;
  typedef color_t [COL_CNT-1:0]             row_t;
  typedef row_t   [ROW_CNT-1:0]             field_t;   // field[0] is the top row

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SCAN,
    ST_BLINK,
    ST_COLLAPSE,
    ST_FILL,
    ST_DONE
  } state_e;

endpackage

// File: rtl/line_clear_ctrl_row_full_detect.sv
// Combinational full-row detector: a row is full when no cell holds color 0.
module line_clear_ctrl_row_full_detect
  import line_clear_ctrl_pkg::*;
(
  input  row_t row_i,
  output logic full_o
);

  logic [COL_CNT-1:0] occ;

  for (genvar c = 0; c < COL_CNT; c++) begin : g_cell
    assign occ[c] = |row_i[c];
  end

  assign full_o = &occ;

endmodule

// File: rtl/line_clear_ctrl.sv
// Line-clear sequencer: snapshot the field, find full rows, blink them via a
// per-row hide mask, then compact the field bottom-up and zero-fill the top.
module line_clear_ctrl
  import line_clear_ctrl_pkg::*;
#(
  parameter int BLINK_FRAMES = BLINK_FRAMES_DEF,
  parameter int BLINK_CNT    = BLINK_CNT_DEF
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               start_i,
  input  field_t             field_i,
  input  logic               frame_tick_i,
  output logic               busy_o,
  output logic               done_o,
  output field_t             field_o,
  output logic [ROW_CNT-1:0] hide_rows_o,
  output logic [LINES_W-1:0] lines_cleared_o
);

  localparam int FRM_W = $clog2(BLINK_FRAMES + 1);
  localparam int PH_W  = $clog2(2 * BLINK_CNT + 1);

  localparam logic [FRM_W-1:0]        FRM_LAST = FRM_W'(BLINK_FRAMES - 1);
  localparam logic [PH_W-1:0]         PH_LAST  = PH_W'(2 * BLINK_CNT - 1);
  localparam logic [ROW_W-1:0]        ROW_LAST = ROW_W'(ROW_CNT - 1);
  localparam logic signed [PTR_W-1:0] PTR_TOP  = PTR_W'(ROW_CNT - 1);

  state_e                    state_q;
  field_t                    field_q;
  logic [ROW_CNT-1:0]        hide_q;
  logic [ROW_CNT-1:0]        full_mask_q;
  logic [LINES_W-1:0]        lines_q;
  logic                      busy_q;
  logic                      done_q;
  logic [ROW_W-1:0]          row_ptr_q;
  logic [FRM_W-1:0]          frm_q;
  logic [PH_W-1:0]           ph_q;
  logic signed [PTR_W-1:0]   rd_q;
  logic signed [PTR_W-1:0]   wr_q;

  logic                      row_full;
  logic [ROW_CNT-1:0]        full_mask_d;
  logic [LINES_W-1:0]        lines_d;
  logic signed [PTR_W-1:0]   rd_d;
  logic signed [PTR_W-1:0]   wr_d;
  logic signed [PTR_W-1:0]   wr_next;
  logic [ROW_W-1:0]          rd_idx;
  logic [ROW_W-1:0]          wr_idx;

  // Scan works on the latched copy, one row per cycle.
  line_clear_ctrl_row_full_detect u_row_full (
    .row_i  (field_q[row_ptr_q]),
    .full_o (row_full)
  );

  assign rd_idx  = rd_q[ROW_W-1:0];
  assign wr_idx  = wr_q[ROW_W-1:0];
  assign rd_d    = rd_q - PTR_W'(1);
  assign wr_d    = wr_q - PTR_W'(1);
  // Write pointer as it stands after the current collapse step.
  assign wr_next = full_mask_q[rd_idx] ? wr_q : wr_d;

  // Mask and count including the row currently under the scan pointer.
  always_comb begin
    full_mask_d = full_mask_q;
    lines_d     = lines_q;
    if (row_full) begin
      full_mask_d[row_ptr_q] = 1'b1;
      lines_d                = lines_q + 1'b1;
    end
  end

  // Sequencer FSM; every output comes straight from a register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      field_q     <= '0;
      hide_q      <= '0;
      full_mask_q <= '0;
      lines_q     <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      row_ptr_q   <= '0;
      frm_q       <= '0;
      ph_q        <= '0;
      rd_q        <= '0;
      wr_q        <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start_i) begin
            field_q     <= field_i;
            full_mask_q <= '0;
            lines_q     <= '0;
            row_ptr_q   <= '0;
            busy_q      <= 1'b1;
            state_q     <= ST_SCAN;
          end
        end

        ST_SCAN: begin
          full_mask_q <= full_mask_d;
          lines_q     <= lines_d;
          row_ptr_q   <= row_ptr_q + 1'b1;
          if (row_ptr_q == ROW_LAST) begin
            row_ptr_q <= '0;
            frm_q     <= '0;
            ph_q      <= '0;
            if (full_mask_d != '0) begin
              hide_q  <= full_mask_d;   // phase 0 hides the full rows
              state_q <= ST_BLINK;
            end else begin
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= ST_DONE;
            end
          end
        end

        ST_BLINK: begin
          if (frame_tick_i) begin
            if (frm_q == FRM_LAST) begin
              frm_q <= '0;
              if (ph_q == PH_LAST) begin
                ph_q    <= '0;
                hide_q  <= '0;
                rd_q    <= PTR_TOP;
                wr_q    <= PTR_TOP;
                state_q <= ST_COLLAPSE;
              end else begin
                ph_q   <= ph_q + 1'b1;
                // Next phase has the opposite parity of the current one.
                hide_q <= ph_q[0] ? full_mask_q : '0;
              end
            end else begin
              frm_q <= frm_q + 1'b1;
            end
          end
        end

        ST_COLLAPSE: begin
          rd_q <= rd_d;
          if (!full_mask_q[rd_idx]) begin
            field_q[wr_idx] <= field_q[rd_idx];
            wr_q            <= wr_d;
          end
          if (rd_d[PTR_W-1]) begin
            if (!wr_next[PTR_W-1]) begin
              state_q <= ST_FILL;
            end else begin
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= ST_DONE;
            end
          end
        end

        ST_FILL: begin
          field_q[wr_idx] <= '0;
          wr_q            <= wr_d;
          if (wr_d[PTR_W-1]) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= ST_DONE;
          end
        end

        ST_DONE: begin
          state_q <= ST_IDLE;
        end

        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign busy_o          = busy_q;
  assign done_o          = done_q;
  assign field_o         = field_q;
  assign hide_rows_o     = hide_q;
  assign lines_cleared_o = lines_q;

endmodule
